// File: rtl/snitch_pkg.sv
// ============================================================================
// Module      : snitch_pkg
// Description : Shared types and constants for the FPU writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snitch_pkg;

  // Width of the accrued IEEE exception flags (NV, DZ, OF, UF, NX).
  localparam int FFLAGS_W = 5;

  // Tag that travels with every FPU operation.
  typedef struct packed {
    logic       rsvd;
    logic       int_dst;
    logic [4:0] rd;
  } fpu_tag_t;

endpackage

`default_nettype wire

// File: rtl/snitch_fpu_wb_int_reg.sv
// ============================================================================
// Module      : snitch_fpu_wb_int_reg
// Description : One-entry valid/ready output register. Accepts a new word
//               whenever empty or draining the same cycle, giving full
//               throughput with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snitch_fpu_wb_int_reg #(
  parameter int DW = 37
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // A slot is free when empty or when the current word leaves this cycle.
  assign in_ready_o  = ~r_valid | out_ready_i;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;

  // Hold the entry until the consumer takes it; reload on every accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        r_valid <= 1'b1;
        r_data  <= in_data_i;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snitch_fpu_wb.sv
// ============================================================================
// Module      : snitch_fpu_wb
// Description : FPU writeback stage. Steers FPU results by tag to the FP
//               register file (arbitrated against FP loads with starvation
//               protection) or to a registered integer result stream. Also
//               accrues sticky fflags and keeps the FP pending scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snitch_fpu_wb
  import snitch_pkg::*;
#(
  parameter int FLEN     = 64,
  parameter int MaxStall = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FLEN-1:0]     fpu_result_i,
  input  logic [FFLAGS_W-1:0] fpu_status_i,
  input  logic [6:0]          fpu_tag_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic [FLEN-1:0]     lsu_data_i,
  input  logic [4:0]          lsu_rd_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  output logic                fpr_we_o,
  output logic [4:0]          fpr_waddr_o,
  output logic [FLEN-1:0]     fpr_wdata_o,
  output logic                int_valid_o,
  input  logic                int_ready_i,
  output logic [4:0]          int_rd_o,
  output logic [31:0]         int_data_o,
  input  logic                sb_set_i,
  input  logic [4:0]          sb_rd_i,
  output logic [31:0]         sb_busy_o,
  output logic [FFLAGS_W-1:0] fflags_o,
  input  logic                fflags_clr_i
);

  localparam logic [3:0] c_max_stall = 4'(MaxStall);

  fpu_tag_t              w_tag;
  logic                  w_fpu_valid;
  logic                  w_lsu_valid;
  logic                  w_fpu_fp;
  logic                  w_fpu_int;
  logic                  w_force_fpu;
  logic                  w_lsu_win;
  logic                  w_fpu_win;
  logic                  w_int_in_ready;
  logic                  w_fpu_accept;
  logic [31:0]           w_sb_set_mask;
  logic [31:0]           w_sb_clr_mask;
  logic                  w_unused_tag_rsvd;
  logic [3:0]            r_stall_cnt;
  logic [31:0]           r_sb_busy;
  logic [FFLAGS_W-1:0]   r_fflags;

  assign w_tag             = fpu_tag_i;
  assign w_unused_tag_rsvd = w_tag.rsvd;

  // Nothing is consumed while reset is held, so every output reads zero.
  assign w_fpu_valid = fpu_valid_i & ~rst_i;
  assign w_lsu_valid = lsu_valid_i & ~rst_i;

  assign w_fpu_fp  = w_fpu_valid & ~w_tag.int_dst;
  assign w_fpu_int = w_fpu_valid &  w_tag.int_dst;

  // Loads normally win; after MaxStall consecutive losses the FPU is forced.
  assign w_force_fpu = (r_stall_cnt == c_max_stall);
  assign w_lsu_win   = w_lsu_valid & ~(w_fpu_fp & w_force_fpu);
  assign w_fpu_win   = w_fpu_fp & ~w_lsu_win;

  assign lsu_ready_o  = w_lsu_win;
  assign fpu_ready_o  = w_fpu_win | (w_fpu_int & w_int_in_ready);
  assign w_fpu_accept = w_fpu_valid & fpu_ready_o;

  // Zero-latency FP register-file write port driven by the arbitration winner.
  always_comb begin
    fpr_we_o    = 1'b0;
    fpr_waddr_o = '0;
    fpr_wdata_o = '0;
    if (w_lsu_win) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = lsu_rd_i;
      fpr_wdata_o = lsu_data_i;
    end else if (w_fpu_win) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = w_tag.rd;
      fpr_wdata_o = fpu_result_i;
    end
  end

  // Count consecutive FPU losses; any FPU win or idle FPU restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_fpu_fp && w_lsu_win) begin
      r_stall_cnt <= r_stall_cnt + 4'd1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  // Sticky flags: a CSR clear takes effect before the same-cycle accrual.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fflags <= '0;
    end else if (fflags_clr_i) begin
      r_fflags <= w_fpu_accept ? fpu_status_i : '0;
    end else if (w_fpu_accept) begin
      r_fflags <= r_fflags | fpu_status_i;
    end
  end

  assign fflags_o = r_fflags;

  assign w_sb_set_mask = sb_set_i ? (32'h1 << sb_rd_i) : 32'h0;
  assign w_sb_clr_mask = fpr_we_o ? (32'h1 << fpr_waddr_o) : 32'h0;

  // Pending scoreboard: writeback clears, issue sets, set wins on collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sb_busy <= '0;
    end else begin
      r_sb_busy <= (r_sb_busy & ~w_sb_clr_mask) | w_sb_set_mask;
    end
  end

  assign sb_busy_o = r_sb_busy;

  snitch_fpu_wb_int_reg #(
    .DW (37)
  ) u_int_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_fpu_int),
    .in_ready_o  (w_int_in_ready),
    .in_data_i   ({w_tag.rd, fpu_result_i[31:0]}),
    .out_valid_o (int_valid_o),
    .out_ready_i (int_ready_i),
    .out_data_o  ({int_rd_o, int_data_o})
  );

  // Only one source may own the FP write port in any cycle.
  a_one_writer: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_lsu_win && w_fpu_win));

  // A stalled integer result must not change under the consumer.
  a_int_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (int_valid_o && !int_ready_i) |=> ($stable(int_data_o) && $stable(int_rd_o)));

endmodule

`default_nettype wire

// File: tb/tb_snitch_fpu_wb.sv
// ============================================================================
// Module      : tb_snitch_fpu_wb
// Description : Directed self-checking bench for snitch_fpu_wb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snitch_fpu_wb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [6:0]  fpu_tag_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [63:0] lsu_data_i;
  logic [4:0]  lsu_rd_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [63:0] fpr_wdata_o;
  logic        int_valid_o;
  logic        int_ready_i;
  logic [4:0]  int_rd_o;
  logic [31:0] int_data_o;
  logic        sb_set_i;
  logic [4:0]  sb_rd_i;
  logic [31:0] sb_busy_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  snitch_fpu_wb #(.FLEN(64), .MaxStall(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fpu_result_i (fpu_result_i),
    .fpu_status_i (fpu_status_i),
    .fpu_tag_i    (fpu_tag_i),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_ready_o  (fpu_ready_o),
    .lsu_data_i   (lsu_data_i),
    .lsu_rd_i     (lsu_rd_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .fpr_we_o     (fpr_we_o),
    .fpr_waddr_o  (fpr_waddr_o),
    .fpr_wdata_o  (fpr_wdata_o),
    .int_valid_o  (int_valid_o),
    .int_ready_i  (int_ready_i),
    .int_rd_o     (int_rd_o),
    .int_data_o   (int_data_o),
    .sb_set_i     (sb_set_i),
    .sb_rd_i      (sb_rd_i),
    .sb_busy_o    (sb_busy_o),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    fpu_valid_i = 1'b0; lsu_data_i = '0; lsu_rd_i = '0; lsu_valid_i = 1'b0;
    int_ready_i = 1'b0; sb_set_i = 1'b0; sb_rd_i = '0; fflags_clr_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_sb", 64'(sb_busy_o), 64'h0);
    check("rst_int_valid", 64'(int_valid_o), 64'h0);
    check("rst_fflags", 64'(fflags_o), 64'h0);

    // ---- Reset mid-transfer -------------------------------------------
    sb_set_i = 1'b1; sb_rd_i = 5'd4;
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h25; fpu_result_i = 64'h0000_0000_CAFE_F00D;
    tick();
    sb_set_i = 1'b0; fpu_valid_i = 1'b0;
    #1;
    check("pre_rst_sb", 64'(sb_busy_o), 64'h10);
    check("pre_rst_int_valid", 64'(int_valid_o), 64'h1);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 64'h55;
    rst_i = 1'b1;
    #1;
    check("async_int_valid", 64'(int_valid_o), 64'h0);
    check("async_int_data", 64'(int_data_o), 64'h0);
    check("async_int_rd", 64'(int_rd_o), 64'h0);
    check("async_sb", 64'(sb_busy_o), 64'h0);
    check("async_fpr_we", 64'(fpr_we_o), 64'h0);
    check("async_lsu_ready", 64'(lsu_ready_o), 64'h0);
    tick();
    rst_i = 1'b0; lsu_valid_i = 1'b0;
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h25;
    #1;
    check("post_rst_fpu_ready", 64'(fpu_ready_o), 64'h1);
    fpu_valid_i = 1'b0;
    sb_set_i = 1'b1; sb_rd_i = 5'd3;
    tick();
    sb_set_i = 1'b0;
    #1;
    check("sb_set_rd3", 64'(sb_busy_o), 64'h8);

    // ---- Arbitration with MaxStall=4 ----------------------------------
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd1; lsu_data_i = 64'hAAAA;
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h07; fpu_result_i = 64'hBBBB; fpu_status_i = '0;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("arb_we_c%0d", c), 64'(fpr_we_o), 64'h1);
      check($sformatf("arb_addr_c%0d", c), 64'(fpr_waddr_o), (c == 4) ? 64'd7 : 64'd1);
      check($sformatf("arb_data_c%0d", c), fpr_wdata_o, (c == 4) ? 64'hBBBB : 64'hAAAA);
      check($sformatf("arb_lsu_rdy_c%0d", c), 64'(lsu_ready_o), (c == 4) ? 64'h0 : 64'h1);
      check($sformatf("arb_fpu_rdy_c%0d", c), 64'(fpu_ready_o), (c == 4) ? 64'h1 : 64'h0);
      tick();
    end
    lsu_valid_i = 1'b0;
    #1;
    check("fpu_only_addr", 64'(fpr_waddr_o), 64'd7);
    check("fpu_only_rdy", 64'(fpu_ready_o), 64'h1);
    fpu_valid_i = 1'b0;
    #1;
    check("idle_we", 64'(fpr_we_o), 64'h0);

    // ---- Integer backpressure -----------------------------------------
    int_ready_i = 1'b0;
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h25; fpu_result_i = 64'hDEAD_0000_1234_5678;
    #1;
    check("int_acc_rdy", 64'(fpu_ready_o), 64'h1);
    tick();
    fpu_tag_i = 7'h26; fpu_result_i = 64'h0000_0000_9ABC_DEF0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_valid_c%0d", c), 64'(int_valid_o), 64'h1);
      check($sformatf("bp_rd_c%0d", c), 64'(int_rd_o), 64'd5);
      check($sformatf("bp_data_c%0d", c), 64'(int_data_o), 64'h1234_5678);
      check($sformatf("bp_fpu_rdy_c%0d", c), 64'(fpu_ready_o), 64'h0);
      tick();
    end
    int_ready_i = 1'b1;
    #1;
    check("bp_drain_rdy", 64'(fpu_ready_o), 64'h1);
    tick();
    fpu_valid_i = 1'b0;
    #1;
    check("bp_second_rd", 64'(int_rd_o), 64'd6);
    check("bp_second_data", 64'(int_data_o), 64'h9ABC_DEF0);
    tick();
    check("bp_empty", 64'(int_valid_o), 64'h0);

    // ---- fflags accrual and clear -------------------------------------
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h02; fpu_status_i = 5'b00001;
    tick();
    fpu_status_i = 5'b10000;
    tick();
    fpu_valid_i = 1'b0; fpu_status_i = 5'b11111;
    tick();
    check("ff_accrue", 64'(fflags_o), 64'b10001);
    fflags_clr_i = 1'b1; fpu_valid_i = 1'b1; fpu_status_i = 5'b00100;
    tick();
    fflags_clr_i = 1'b0; fpu_valid_i = 1'b0;
    #1;
    check("ff_clr_and_acc", 64'(fflags_o), 64'b00100);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; fpu_status_i = 5'b01000;
    tick();
    lsu_valid_i = 1'b0;
    #1;
    check("ff_load_untouched", 64'(fflags_o), 64'b00100);
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    #1;
    check("ff_clr_only", 64'(fflags_o), 64'h0);

    // ---- Scoreboard set/clear collision -------------------------------
    fpu_status_i = '0;
    sb_set_i = 1'b1; sb_rd_i = 5'd9;
    tick();
    check("sb_set9", 64'(sb_busy_o[9]), 64'h1);
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h09;
    tick();
    sb_set_i = 1'b0;
    #1;
    check("sb_collide9", 64'(sb_busy_o[9]), 64'h1);
    tick();
    fpu_valid_i = 1'b0;
    #1;
    check("sb_clear9", 64'(sb_busy_o[9]), 64'h0);
    sb_set_i = 1'b1;
    tick();
    sb_set_i = 1'b0;
    fpu_valid_i = 1'b1; fpu_tag_i = 7'h29;
    #1;
    check("sb_int_rdy", 64'(fpu_ready_o), 64'h1);
    tick();
    fpu_valid_i = 1'b0;
    #1;
    check("sb_int_no_clear", 64'(sb_busy_o[9]), 64'h1);
    tick();

    // ---- Integer throughput, tag bit 6 ignored on odd beats -----------
    int_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fpu_valid_i  = 1'b1;
      fpu_tag_i    = {(i % 2 == 1), 1'b1, 5'(10 + i)};
      fpu_result_i = {32'hFFFF_FFFF, 32'h100 + 32'(i)};
      #1;
      check($sformatf("tp_rdy_%0d", i), 64'(fpu_ready_o), 64'h1);
      tick();
      check($sformatf("tp_valid_%0d", i), 64'(int_valid_o), 64'h1);
      check($sformatf("tp_rd_%0d", i), 64'(int_rd_o), 64'(10 + i));
      check($sformatf("tp_data_%0d", i), 64'(int_data_o), 64'h100 + 64'(i));
    end
    fpu_valid_i = 1'b0;
    tick();
    check("tp_drained", 64'(int_valid_o), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
